decode_queue: RTL and testbench
===============================

# decode_queue

- Buffers decoded instructions between the front-end decoder and the back-end rename stage.
- Elastic valid/ready FIFO of DEPTH entries that decouples decoder throughput from rename stalls.
- Discards all buffered, wrong-path instructions in one cycle when the back end signals a mispredict.
- Feeds `decoded_i` / `decoded_v_i` of the back-end top and consumes its `rename_decode_ready_o`.

## Interface
Parameters:
- WIDTH, default DECODED_INSTRUCTION_WIDTH: bits per decoded instruction.
- DEPTH, default 8: number of entries. Must be a power of two, ≥ 2.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- reset_i  input  1  reset; asynchronous, active-low.
- dec_v_i  input  1  decoder presents an instruction.
- dec_i  input  WIDTH  decoded instruction payload.
- dec_ready_o  output  1  queue can accept an instruction this cycle.
- decoded_v_o  output  1  head entry valid; drives the back end's `decoded_v_i`.
- decoded_o  output  WIDTH  head entry payload; drives the back end's `decoded_i`.
- rename_ready_i  input  1  rename accepts the head; driven by `rename_decode_ready_o`.
- mispredict_i  input  1  flush request; driven by `be_fe_mispredict_o`.
- count_o  output  $clog2(DEPTH)+1  number of occupied entries.
- overflow_err_o  output  1  sticky flag: a push was attempted while `dec_ready_o` = 0.

## Operation
**State**
- Storage array of DEPTH × WIDTH.
- Write and read pointers, each $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
- Sticky error flag.

**Status**
- Empty: pointers equal.
- Full: index bits equal and wrap bits differ.
- `count_o` = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).

**Handshakes**
- push = `dec_v_i` & `dec_ready_o`.
- pop = `decoded_v_o` & `rename_ready_i`.
- `dec_ready_o` = !full. It does not look at pop in the same cycle, so there is no combinational path from `rename_ready_i` to `dec_ready_o`.
- `decoded_v_o` = !empty.
- `decoded_o` = mem[rd_ptr index]. It holds stable while `decoded_v_o` = 1 and there is no pop.

**Updates**
- Push writes mem[wr_ptr index] and increments wr_ptr. Pop increments rd_ptr.
- Push and pop in the same cycle: both happen and the count is unchanged. This is legal at any non-full occupancy, including when empty-side and full-side conditions are not met.
- Empty and pushed: the entry is not bypassed. `decoded_v_o` rises the next cycle.

**Flush**
- `mispredict_i` = 1 sets rd_ptr := wr_ptr := 0.
- Any push or pop in that cycle is discarded, including the incoming decoder instruction.
- Storage contents need not be cleared.
- Flush has priority over push and pop.

**Error flag**
- `dec_v_i` & !`dec_ready_o` & !`mispredict_i` sets `overflow_err_o`.
- It clears only on reset.

**Reset**
- reset_i = 0 immediately sets pointers to 0 and the error flag to 0.
- Resulting outputs: `dec_ready_o` = 1, `decoded_v_o` = 0, `count_o` = 0, `overflow_err_o` = 0.
- `decoded_o` is don't-care while invalid.
- Asserting reset mid-stream drops every entry.

## Timing
- Latency from push to visibility at the head: 1 cycle.
- Throughput: 1 push and 1 pop per cycle, sustained.
- Flush in cycle N: `decoded_v_o` = 0 and `count_o` = 0 from cycle N+1. A push in cycle N+1 is accepted normally.
- Full: `dec_ready_o` = 0. A pop in cycle N re-asserts `dec_ready_o` in cycle N+1.
- Wrap-around: an index roll-over flips the wrap bit. Full/empty detection must hold across unlimited wraps.
- All outputs are functions of registered state only; `decoded_o` is a combinational read of the array.

## Test plan
- **Reset and basic push:** release reset, then push 0xA1, 0xA2, 0xA3 on consecutive cycles with `rename_ready_i` = 0.
  - Expect `decoded_v_o` from cycle 2, `decoded_o` = 0xA1 held stable, `count_o` = 3.
- **Fill to full (DEPTH = 8):** push 9 instructions with `rename_ready_i` = 0.
  - Expect `dec_ready_o` = 0 after the 8th push and `count_o` = 8.
  - Holding the 9th with `dec_v_i` = 1 sets `overflow_err_o` = 1.
  - Then pop once: `dec_ready_o` = 1 the next cycle and `count_o` = 7.
- **Streaming and wrap:** with `rename_ready_i` = 1, push 100 sequential values 0..99.
  - Expect pops in order 0..99 with one-cycle latency, `count_o` ≤ 1, no drops, and correct behaviour across multiple pointer wraps.
- **Mispredict flush:** with 5 entries buffered, assert `mispredict_i` together with `dec_v_i` carrying 0xFF.
  - Next cycle: `count_o` = 0, `decoded_v_o` = 0, and 0xFF is never output.
  - A following push of 0x10 appears at the head one cycle later.
- **Asynchronous reset mid-operation:** with 4 entries, pull reset_i low between clock edges.
  - Outputs go to reset values before the next edge.
  - After release, the queue is empty and `overflow_err_o` = 0.
- **Random stall:** random `dec_v_i` and `rename_ready_i` at 50% with occasional `mispredict_i`, checked against a scoreboard model.
  - Expect exact ordering and zero loss or duplication outside flushes.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: elastic FIFO between decoder and rename; head visible 1 cycle after push, no bypass.
// Backpressure: dec_ready_o = !full from registered state only; mispredict_i drops every entry in one cycle.
`ifndef DECODED_INSTRUCTION_WIDTH
`define DECODED_INSTRUCTION_WIDTH 64
`endif

module decode_queue #(
  parameter int WIDTH = `DECODED_INSTRUCTION_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     dec_v_i,
  input  logic [WIDTH-1:0]         dec_i,
  output logic                     dec_ready_o,
  output logic                     decoded_v_o,
  output logic [WIDTH-1:0]         decoded_o,
  input  logic                     rename_ready_i,
  input  logic                     mispredict_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ovf;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign push = dec_v_i && !full;
  assign pop  = !empty && rename_ready_i;

  assign dec_ready_o    = !full;
  assign decoded_v_o    = !empty;
  assign decoded_o      = mem[rd_ptr[AW-1:0]];
  assign count_o        = wr_ptr - rd_ptr;
  assign overflow_err_o = ovf;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (dec_v_i && full && !mispredict_i) begin
        ovf <= 1'b1;
      end
      if (mispredict_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
    end
  end

  // Payload storage carries no reset; occupancy is governed by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (push && !mispredict_i) begin
      mem[wr_ptr[AW-1:0]] <= dec_i;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed phases plus random stalls, checked by a scoreboard queue
// filled on accepted pushes and drained whenever the DUT hands an entry to rename.
module tb_decode_queue;

  localparam int W = 32;
  localparam int D = 8;

  logic         clk_i;
  logic         reset_i;
  logic         dec_v_i;
  logic [W-1:0] dec_i;
  logic         dec_ready_o;
  logic         decoded_v_o;
  logic [W-1:0] decoded_o;
  logic         rename_ready_i;
  logic         mispredict_i;
  logic [3:0]   count_o;
  logic         overflow_err_o;

  decode_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .dec_v_i        (dec_v_i),
    .dec_i          (dec_i),
    .dec_ready_o    (dec_ready_o),
    .decoded_v_o    (decoded_v_o),
    .decoded_o      (decoded_o),
    .rename_ready_i (rename_ready_i),
    .mispredict_i   (mispredict_i),
    .count_o        (count_o),
    .overflow_err_o (overflow_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] exp_q [$];
  logic         exp_ovf = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model and monitor: outputs sampled mid-cycle, then the coming edge is predicted.
  always @(negedge clk_i) begin
    int  sz;
    logic full_m;
    if (!reset_i) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      sz     = exp_q.size();
      full_m = (sz == D);
      chk("m_count", W'(count_o), W'(sz));
      chk("m_ready", W'(dec_ready_o), W'(!full_m));
      chk("m_valid", W'(decoded_v_o), W'(sz != 0));
      chk("m_ovf", W'(overflow_err_o), W'(exp_ovf));
      if (decoded_v_o && rename_ready_i && !mispredict_i) begin
        if (exp_q.size() == 0) chk("m_spurious_pop", decoded_o, 'x);
        else chk("m_data", decoded_o, exp_q.pop_front());
      end
      if (dec_v_i && full_m && !mispredict_i) exp_ovf = 1'b1;
      if (mispredict_i) exp_q.delete();
      else if (dec_v_i && !full_m) exp_q.push_back(dec_i);
    end
  end

  initial begin
    reset_i        = 1'b0;
    dec_v_i        = 1'b0;
    dec_i          = '0;
    rename_ready_i = 1'b0;
    mispredict_i   = 1'b0;
    step();
    step();
    reset_i = 1'b1;
    chk("rst_ready", W'(dec_ready_o), 1);
    chk("rst_valid", W'(decoded_v_o), 0);
    chk("rst_count", W'(count_o), 0);
    chk("rst_ovf", W'(overflow_err_o), 0);

    // Basic push, no pops
    dec_v_i = 1'b1; dec_i = 32'hA1;
    step();
    chk("p1_valid", W'(decoded_v_o), 1);
    chk("p1_head", decoded_o, 32'hA1);
    dec_i = 32'hA2; step();
    dec_i = 32'hA3; step();
    dec_v_i = 1'b0;
    chk("p3_count", W'(count_o), 3);
    step();
    step();
    chk("p3_head_hold", decoded_o, 32'hA1);
    chk("p3_count_hold", W'(count_o), 3);

    // Fill to full and overflow attempt
    mispredict_i = 1'b1; step(); mispredict_i = 1'b0;
    for (int i = 0; i < D; i++) begin
      dec_v_i = 1'b1; dec_i = 32'hB0 + i;
      step();
    end
    chk("full_ready", W'(dec_ready_o), 0);
    chk("full_count", W'(count_o), 8);
    dec_i = 32'hB8;
    step();
    dec_v_i = 1'b0;
    chk("full_ovf", W'(overflow_err_o), 1);
    chk("full_count_hold", W'(count_o), 8);
    rename_ready_i = 1'b1; step(); rename_ready_i = 1'b0;
    chk("pop_ready", W'(dec_ready_o), 1);
    chk("pop_count", W'(count_o), 7);
    chk("pop_head", decoded_o, 32'hB1);
    rename_ready_i = 1'b1;
    for (int i = 0; i < D; i++) step();
    chk("drain_count", W'(count_o), 0);
    chk("ovf_sticky", W'(overflow_err_o), 1);

    // Streaming with wraps
    for (int i = 0; i < 100; i++) begin
      dec_v_i = 1'b1; dec_i = W'(i);
      step();
      if (count_o > 1) chk("stream_count_le1", W'(count_o), 1);
    end
    dec_v_i = 1'b0;
    step();
    step();
    chk("stream_empty", W'(count_o), 0);

    // Mispredict flush with a concurrent push
    rename_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dec_v_i = 1'b1; dec_i = 32'h20 + i;
      step();
    end
    chk("pre_flush_count", W'(count_o), 5);
    mispredict_i = 1'b1; dec_i = 32'hFF;
    step();
    mispredict_i = 1'b0; dec_v_i = 1'b0;
    chk("flush_count", W'(count_o), 0);
    chk("flush_valid", W'(decoded_v_o), 0);
    dec_v_i = 1'b1; dec_i = 32'h10;
    step();
    dec_v_i = 1'b0;
    chk("post_flush_valid", W'(decoded_v_o), 1);
    chk("post_flush_head", decoded_o, 32'h10);
    chk("post_flush_count", W'(count_o), 1);
    rename_ready_i = 1'b1; step(); rename_ready_i = 1'b0;

    // Asynchronous reset between edges
    for (int i = 0; i < 4; i++) begin
      dec_v_i = 1'b1; dec_i = 32'h30 + i;
      step();
    end
    dec_v_i = 1'b0;
    chk("pre_rst_count", W'(count_o), 4);
    #2 reset_i = 1'b0;
    #1;
    chk("arst_ready", W'(dec_ready_o), 1);
    chk("arst_valid", W'(decoded_v_o), 0);
    chk("arst_count", W'(count_o), 0);
    chk("arst_ovf", W'(overflow_err_o), 0);
    step();
    reset_i = 1'b1;
    step();
    chk("post_rst_count", W'(count_o), 0);
    chk("post_rst_valid", W'(decoded_v_o), 0);
    chk("post_rst_ovf", W'(overflow_err_o), 0);

    // Random stalls with occasional flushes
    for (int i = 0; i < 500; i++) begin
      dec_v_i        = 1'($urandom_range(0, 1));
      dec_i          = $urandom;
      rename_ready_i = 1'($urandom_range(0, 1));
      mispredict_i   = ($urandom_range(0, 19) == 0);
      step();
    end
    dec_v_i = 1'b0; mispredict_i = 1'b0; rename_ready_i = 1'b1;
    for (int i = 0; i < D + 2; i++) step();
    chk("rand_drain_count", W'(count_o), 0);
    chk("rand_sb_empty", W'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
